// File: rtl/fir_requant_if.sv
// AXI-Stream bundle for the requantiser: the Q2.30 input stream and the
// Q1.15 output stream, with tuser carrying the per-beat saturation flag.
interface fir_requant_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
);
    logic [IN_W-1:0]  s_axis_rq_tdata;
    logic             s_axis_rq_tvalid;
    logic             s_axis_rq_tlast;
    logic             s_axis_rq_tready;
    logic [OUT_W-1:0] m_axis_rq_tdata;
    logic             m_axis_rq_tvalid;
    logic             m_axis_rq_tlast;
    logic             m_axis_rq_tuser;
    logic             m_axis_rq_tready;

    // Environment side: feeds the input stream and consumes the output stream.
    modport master (
        output s_axis_rq_tdata, s_axis_rq_tvalid, s_axis_rq_tlast,
        input  s_axis_rq_tready,
        input  m_axis_rq_tdata, m_axis_rq_tvalid, m_axis_rq_tlast, m_axis_rq_tuser,
        output m_axis_rq_tready
    );

    // Requantiser side.
    modport slave (
        input  s_axis_rq_tdata, s_axis_rq_tvalid, s_axis_rq_tlast,
        output s_axis_rq_tready,
        output m_axis_rq_tdata, m_axis_rq_tvalid, m_axis_rq_tlast, m_axis_rq_tuser,
        input  m_axis_rq_tready
    );
endinterface

// File: rtl/fir_requant.sv
// Requantises the FIR's signed IN_W result to OUT_W bits: round half-up,
// arithmetic right shift by SHIFT, saturate. A two-entry skid buffer (main M,
// skid S) keeps tready registered while sustaining one beat per cycle.
// The interface instance must be parameterised with the same IN_W/OUT_W.
module fir_requant #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 15,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    fir_requant_if.slave     rq,
    input  logic             sat_clr,
    output logic [CNT_W-1:0] sat_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Rounding constant and saturation bounds at the widened (IN_W+1) width.
    localparam logic signed [IN_W:0] RND   = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [IN_W:0] Q_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] Q_MIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0]     OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]     OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]     CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]     CNT_MAX = {CNT_W{1'b1}};

    state_t             state_r, next_state_s;
    logic               ready_r;
    logic               m_valid_r;
    logic [OUT_W-1:0]   m_data_r, s_data_r;
    logic               m_last_r, s_last_r;
    logic               m_sat_r, s_sat_r;
    logic [CNT_W-1:0]   sat_count_r;

    logic signed [IN_W:0] sum_s;
    logic signed [IN_W:0] q_s;
    logic [OUT_W-1:0]     data_in_s;
    logic                 sat_in_s;
    logic                 accept_s, drain_s;
    logic                 load_m_in_s, load_s_in_s, move_s_m_s;

    assign accept_s = rq.s_axis_rq_tvalid && ready_r;
    assign drain_s  = m_valid_r && rq.m_axis_rq_tready;

    // Round half-up, shift back to the output scale and clamp to OUT_W bits.
    always_comb begin
        sum_s     = $signed({rq.s_axis_rq_tdata[IN_W-1], rq.s_axis_rq_tdata}) + RND;
        q_s       = sum_s >>> SHIFT;
        data_in_s = q_s[OUT_W-1:0];
        sat_in_s  = 1'b0;
        if (q_s > Q_MAX) begin
            data_in_s = OUT_MAX;
            sat_in_s  = 1'b1;
        end else if (q_s < Q_MIN) begin
            data_in_s = OUT_MIN;
            sat_in_s  = 1'b1;
        end else begin
            data_in_s = q_s[OUT_W-1:0];
            sat_in_s  = 1'b0;
        end
    end

    // Skid-buffer next state and the M/S load controls.
    always_comb begin
        next_state_s = state_r;
        load_m_in_s  = 1'b0;
        load_s_in_s  = 1'b0;
        move_s_m_s   = 1'b0;
        case (state_r)
            EMPTY: begin
                if (accept_s) begin
                    load_m_in_s  = 1'b1;
                    next_state_s = ONE;
                end else begin
                    next_state_s = EMPTY;
                end
            end
            ONE: begin
                if (accept_s && !drain_s) begin
                    load_s_in_s  = 1'b1;
                    next_state_s = FULL;
                end else if (accept_s && drain_s) begin
                    load_m_in_s  = 1'b1;
                    next_state_s = ONE;
                end else if (drain_s) begin
                    next_state_s = EMPTY;
                end else begin
                    next_state_s = ONE;
                end
            end
            FULL: begin
                if (drain_s) begin
                    move_s_m_s   = 1'b1;
                    next_state_s = ONE;
                end else begin
                    next_state_s = FULL;
                end
            end
            default: begin
                next_state_s = EMPTY;
            end
        endcase
    end

    // State register with registered ready/valid decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= EMPTY;
            ready_r   <= 1'b0;
            m_valid_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            ready_r   <= (next_state_s != FULL);
            m_valid_r <= (next_state_s != EMPTY);
        end
    end

    // Main register: loads a new beat or takes over the skid entry; otherwise holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data_r <= '0;
            m_last_r <= 1'b0;
            m_sat_r  <= 1'b0;
        end else if (load_m_in_s) begin
            m_data_r <= data_in_s;
            m_last_r <= rq.s_axis_rq_tlast;
            m_sat_r  <= sat_in_s;
        end else if (move_s_m_s) begin
            m_data_r <= s_data_r;
            m_last_r <= s_last_r;
            m_sat_r  <= s_sat_r;
        end
    end

    // Skid register: captures the beat accepted while M is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_data_r <= '0;
            s_last_r <= 1'b0;
            s_sat_r  <= 1'b0;
        end else if (load_s_in_s) begin
            s_data_r <= data_in_s;
            s_last_r <= rq.s_axis_rq_tlast;
            s_sat_r  <= sat_in_s;
        end
    end

    // Saturating count of saturated accepts; a clear coinciding with one leaves 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_count_r <= '0;
        end else if (sat_clr) begin
            sat_count_r <= (accept_s && sat_in_s) ? CNT_ONE : '0;
        end else if (accept_s && sat_in_s && (sat_count_r != CNT_MAX)) begin
            sat_count_r <= sat_count_r + CNT_ONE;
        end
    end

    assign rq.s_axis_rq_tready = ready_r;
    assign rq.m_axis_rq_tvalid = m_valid_r;
    assign rq.m_axis_rq_tdata  = m_data_r;
    assign rq.m_axis_rq_tlast  = m_last_r;
    assign rq.m_axis_rq_tuser  = m_sat_r;
    assign sat_count           = sat_count_r;

endmodule

// File: tb/tb_fir_requant.sv
// Directed bench for fir_requant: rounding, saturation, backpressure, full
// stall, counter limits (a CNT_W=2 twin shares the stimulus) and async reset.
module tb_fir_requant;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sat_clr = 1'b0;
    logic [15:0] sat_count;
    logic [1:0]  sat_count2;

    int n_checks = 0;
    int n_fail   = 0;

    fir_requant_if #(.IN_W(32), .OUT_W(16)) rq ();
    fir_requant_if #(.IN_W(32), .OUT_W(16)) rq2 ();

    assign rq2.s_axis_rq_tdata  = rq.s_axis_rq_tdata;
    assign rq2.s_axis_rq_tvalid = rq.s_axis_rq_tvalid;
    assign rq2.s_axis_rq_tlast  = rq.s_axis_rq_tlast;
    assign rq2.m_axis_rq_tready = rq.m_axis_rq_tready;

    fir_requant #(.IN_W(32), .OUT_W(16), .SHIFT(15), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .rq(rq), .sat_clr(sat_clr), .sat_count(sat_count)
    );

    fir_requant #(.IN_W(32), .OUT_W(16), .SHIFT(15), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .rq(rq2), .sat_clr(sat_clr), .sat_count(sat_count2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    logic [31:0] rnd_in  [4] = '{32'h0000_4000, 32'hFFFF_C000, 32'hFFFF_BFFF, 32'h0000_3FFF};
    logic [31:0] rnd_out [4] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_FFFF, 32'h0000_0000};
    logic [31:0] sat_in  [3] = '{32'h3FFF_FFFF, 32'h8000_0000, 32'hC000_0000};
    logic [31:0] sat_out [3] = '{32'h0000_7FFF, 32'h0000_8000, 32'h0000_8000};
    logic        sat_usr [3] = '{1'b1, 1'b1, 1'b0};
    logic        pat     [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int k, out_idx, occ, cyc, nacc;
        logic acc, drn, stall_now;
        logic [15:0] held;
        logic held_last;

        rq.s_axis_rq_tdata  = 32'h0;
        rq.s_axis_rq_tvalid = 1'b0;
        rq.s_axis_rq_tlast  = 1'b0;
        rq.m_axis_rq_tready = 1'b0;

        // ---- reset values
        #1 reset = 1'b1;
        tick();
        tick();
        check("rst_tready", 32'(rq.s_axis_rq_tready), 32'h0);
        check("rst_tvalid", 32'(rq.m_axis_rq_tvalid), 32'h0);
        check("rst_tdata",  32'(rq.m_axis_rq_tdata),  32'h0);
        check("rst_tlast",  32'(rq.m_axis_rq_tlast),  32'h0);
        check("rst_tuser",  32'(rq.m_axis_rq_tuser),  32'h0);
        check("rst_satcnt", 32'(sat_count),           32'h0);
        reset = 1'b0;
        tick();
        check("rst_release_tready", 32'(rq.s_axis_rq_tready), 32'h1);

        // ---- rounding, ready held high
        rq.m_axis_rq_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rq.s_axis_rq_tdata  = rnd_in[i];
            rq.s_axis_rq_tvalid = 1'b1;
            tick();
            check("rnd_valid", 32'(rq.m_axis_rq_tvalid), 32'h1);
            check("rnd_data",  32'(rq.m_axis_rq_tdata),  rnd_out[i]);
            check("rnd_user",  32'(rq.m_axis_rq_tuser),  32'h0);
        end

        // ---- saturation
        for (int i = 0; i < 3; i++) begin
            rq.s_axis_rq_tdata  = sat_in[i];
            rq.s_axis_rq_tvalid = 1'b1;
            tick();
            check("sat_data", 32'(rq.m_axis_rq_tdata), sat_out[i]);
            check("sat_user", 32'(rq.m_axis_rq_tuser), 32'(sat_usr[i]));
        end
        rq.s_axis_rq_tvalid = 1'b0;
        tick();
        check("sat_count", 32'(sat_count), 32'd2);
        check("sat_drained", 32'(rq.m_axis_rq_tvalid), 32'h0);

        // ---- backpressure with toggling downstream ready
        k = 1; out_idx = 0; occ = 0; cyc = 0;
        while (out_idx < 8 && cyc < 80) begin
            rq.m_axis_rq_tready = pat[cyc % 6];
            rq.s_axis_rq_tvalid = (k <= 8);
            rq.s_axis_rq_tdata  = 32'(k) << 15;
            rq.s_axis_rq_tlast  = (k == 8);
            acc = rq.s_axis_rq_tvalid && rq.s_axis_rq_tready;
            drn = rq.m_axis_rq_tvalid && rq.m_axis_rq_tready;
            if (drn) begin
                out_idx++;
                check("bp_data", 32'(rq.m_axis_rq_tdata), 32'(out_idx));
                check("bp_last", 32'(rq.m_axis_rq_tlast), 32'(out_idx == 8));
            end
            stall_now = rq.m_axis_rq_tvalid && !rq.m_axis_rq_tready;
            held      = rq.m_axis_rq_tdata;
            held_last = rq.m_axis_rq_tlast;
            tick();
            if (acc) k++;
            occ = occ + int'(acc) - int'(drn);
            check("bp_ready", 32'(rq.s_axis_rq_tready), 32'(occ != 2));
            if (stall_now) begin
                check("bp_hold_valid", 32'(rq.m_axis_rq_tvalid), 32'h1);
                check("bp_hold_data",  32'(rq.m_axis_rq_tdata),  32'(held));
                check("bp_hold_last",  32'(rq.m_axis_rq_tlast),  32'(held_last));
            end
            cyc++;
        end
        check("bp_out_count", 32'(out_idx), 32'd8);
        rq.s_axis_rq_tvalid = 1'b0;
        rq.s_axis_rq_tlast  = 1'b0;
        tick();
        check("bp_empty", 32'(rq.m_axis_rq_tvalid), 32'h0);

        // ---- full stall
        rq.m_axis_rq_tready = 1'b0;
        k = 9; nacc = 0;
        repeat (5) begin
            rq.s_axis_rq_tvalid = 1'b1;
            rq.s_axis_rq_tdata  = 32'(k) << 15;
            acc = rq.s_axis_rq_tready;
            tick();
            if (acc) begin
                k++;
                nacc++;
            end
        end
        check("stall_accepts", 32'(nacc), 32'd2);
        check("stall_tready",  32'(rq.s_axis_rq_tready), 32'h0);
        check("stall_head",    32'(rq.m_axis_rq_tdata),  32'd9);
        rq.s_axis_rq_tvalid = 1'b0;
        rq.m_axis_rq_tready = 1'b1;
        tick();
        check("stall_second_valid", 32'(rq.m_axis_rq_tvalid), 32'h1);
        check("stall_second_data",  32'(rq.m_axis_rq_tdata),  32'd10);
        check("stall_ready_back",   32'(rq.s_axis_rq_tready), 32'h1);
        tick();
        check("stall_empty", 32'(rq.m_axis_rq_tvalid), 32'h0);

        // ---- counter limits (dut2 has a 2-bit counter)
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("clr_alone",  32'(sat_count),  32'd0);
        check("clr_alone2", 32'(sat_count2), 32'd0);
        rq.s_axis_rq_tdata  = 32'h3FFF_FFFF;
        rq.s_axis_rq_tvalid = 1'b1;
        repeat (5) tick();
        rq.s_axis_rq_tvalid = 1'b0;
        tick();
        check("cnt_stick2", 32'(sat_count2), 32'd3);
        check("cnt_five",   32'(sat_count),  32'd5);
        sat_clr = 1'b1;
        rq.s_axis_rq_tvalid = 1'b1;
        tick();
        sat_clr = 1'b0;
        rq.s_axis_rq_tvalid = 1'b0;
        check("clr_with_sat2", 32'(sat_count2), 32'd1);
        check("clr_with_sat",  32'(sat_count),  32'd1);
        tick();

        // ---- reset while FULL
        rq.m_axis_rq_tready = 1'b0;
        rq.s_axis_rq_tdata  = 32'h3FFF_FFFF;
        rq.s_axis_rq_tvalid = 1'b1;
        tick();
        tick();
        rq.s_axis_rq_tvalid = 1'b0;
        check("pre_rst_full",   32'(rq.s_axis_rq_tready), 32'h0);
        check("pre_rst_satcnt", 32'(sat_count), 32'd3);
        #2 reset = 1'b1;
        #1;
        check("async_rst_tvalid", 32'(rq.m_axis_rq_tvalid), 32'h0);
        check("async_rst_tready", 32'(rq.s_axis_rq_tready), 32'h0);
        check("async_rst_satcnt", 32'(sat_count),           32'h0);
        check("async_rst_tdata",  32'(rq.m_axis_rq_tdata),  32'h0);
        #1 reset = 1'b0;
        tick();
        check("post_rst_tready", 32'(rq.s_axis_rq_tready), 32'h1);
        check("post_rst_stale",  32'(rq.m_axis_rq_tvalid), 32'h0);
        rq.m_axis_rq_tready = 1'b1;
        rq.s_axis_rq_tdata  = 32'h0000_8000;
        rq.s_axis_rq_tvalid = 1'b1;
        tick();
        rq.s_axis_rq_tvalid = 1'b0;
        check("post_rst_valid", 32'(rq.m_axis_rq_tvalid), 32'h1);
        check("post_rst_data",  32'(rq.m_axis_rq_tdata),  32'h0000_0001);
        check("post_rst_user",  32'(rq.m_axis_rq_tuser),  32'h0);
        tick();
        check("post_rst_single", 32'(rq.m_axis_rq_tvalid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
